mash_nth_dsm: RTL and testbench

Parametrised MASH 1-1-…-1 delta-sigma modulator, the successor to the fixed third-order modulator inside the fractional-N divider. It adds several features:
- compile-time maximum order and runtime order select (0 = integer-N);
- optional LFSR LSB dither;
- a double-buffered load of integer, fraction and mode.

It runs on the divider feedback clock and delivers the per-cycle division value N = Integer + y to the P/S counter.

---
 rtl/mash_pkg.sv | 33 +++
 rtl/mash_acc_stage.sv | 39 +++
 rtl/mash_nth_dsm.sv | 156 +++++++++++++++
 tb/tb_mash_nth_dsm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mash_pkg
// Description : Shared constants, types and helpers for the MASH 1-1-..-1
//               delta-sigma modulator (order limits, dither LFSR, y width).
// Revision    : 1.0 - initial release
// ============================================================================
package mash_pkg;

  // Order value meaning "integer-N, modulator bypassed"
  localparam int ORDER_INT       = 0;
  // Highest order the architecture is built for
  localparam int ORDER_MAX_LIMIT = 4;

  // Dither LFSR: 23-bit Fibonacci, polynomial x^23 + x^18 + 1
  localparam int LFSR_WIDTH  = 23;
  localparam int LFSR_TAP_HI = 22;
  localparam int LFSR_TAP_LO = 17;

  typedef logic [LFSR_WIDTH-1:0] lfsr_t;

  // Signed output width needed for a modulator of the given order
  function automatic int y_width(input int order);
    return order + 1;
  endfunction

  // One Fibonacci step; new bit enters at the LSB, which is the dither tap
  function automatic lfsr_t lfsr_next(input lfsr_t s);
    return {s[LFSR_WIDTH-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mash_acc_stage.sv
`default_nettype none
// ============================================================================
// Module      : mash_acc_stage
// Description : One first-order accumulator of the MASH chain. Exposes the
//               combinational wrapped sum (input to the next stage) and carry.
// Revision    : 1.0 - initial release
// ============================================================================
module mash_acc_stage #(
  parameter int FRAC_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [FRAC_WIDTH-1:0] in_val,
  input  logic                  cin,
  output logic [FRAC_WIDTH-1:0] sum,
  output logic                  carry
);

  logic [FRAC_WIDTH-1:0] acc;
  logic [FRAC_WIDTH:0]   s_full;

  // F+1 bit sum: acc + in + cin cannot exceed 2^(F+1)-1, so no extra bit needed
  assign s_full = {1'b0, acc} + {1'b0, in_val} + {{FRAC_WIDTH{1'b0}}, cin};
  assign sum    = s_full[FRAC_WIDTH-1:0];
  assign carry  = en & s_full[FRAC_WIDTH];

  // Accumulator wraps modulo 2^F; a disabled stage is held at zero
  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en) begin
      acc <= '0;
    end else begin
      acc <= s_full[FRAC_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mash_nth_dsm.sv
`default_nettype none
// ============================================================================
// Module      : mash_nth_dsm
// Description : Parametrised MASH 1-1-..-1 delta-sigma modulator with runtime
//               order select, optional LFSR LSB dither and double-buffered
//               integer/fraction/mode load. Produces N = int + y per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mash_nth_dsm
  import mash_pkg::*;
#(
  parameter  int                    FRAC_WIDTH = 24,
  parameter  int                    INT_WIDTH  = 8,
  parameter  int                    ORDER_MAX  = 3,
  parameter  logic [LFSR_WIDTH-1:0] LFSR_SEED  = 23'h7FFFFF,
  localparam int                    Y_WIDTH    = y_width(ORDER_MAX)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INT_WIDTH-1:0]      int_i,
  input  logic [FRAC_WIDTH-1:0]     frac_i,
  input  logic [2:0]                order_i,
  input  logic                      dither_en_i,
  input  logic                      load_i,
  output logic signed [Y_WIDTH-1:0] y_o,
  output logic [INT_WIDTH:0]        n_o,
  output logic                      clamp_o
);

  localparam int         ORDER_CAP = (ORDER_MAX > ORDER_MAX_LIMIT) ? ORDER_MAX_LIMIT : ORDER_MAX;
  localparam logic [2:0] ORDER_TOP = 3'(ORDER_CAP);

  // Shadow registers
  logic [INT_WIDTH-1:0]  int_q;
  logic [FRAC_WIDTH-1:0] frac_q;
  logic [2:0]            order_q;
  logic                  dith_q;
  lfsr_t                 lfsr;

  logic [2:0] order_req;
  logic       clr;
  logic       dith_bit;

  // Requests above the built order clamp to it; comparing the clamped value
  // means a request of 7 on a third-order build does not restart the chain
  assign order_req = (order_i > ORDER_TOP) ? ORDER_TOP : order_i;
  assign clr       = load_i && (order_req != order_q);
  assign dith_bit  = dith_q & lfsr[0];

  // Double-buffered settings, loaded on any load_i edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_q   <= '0;
      frac_q  <= '0;
      order_q <= ORDER_TOP;
      dith_q  <= 1'b0;
    end else if (load_i) begin
      int_q   <= int_i;
      frac_q  <= frac_i;
      order_q <= order_req;
      dith_q  <= dither_en_i;
    end
  end

  // Dither source: restarts from the seed on reset or order change
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      lfsr <= LFSR_SEED;
    end else if (dith_q) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Accumulator chain: chain[k] feeds stage k+1, purely combinational
  logic [ORDER_CAP:0][FRAC_WIDTH-1:0] chain;
  logic [ORDER_CAP-1:0]               carry;
  logic                               unused_tail;

  assign chain[0]    = frac_q;
  assign unused_tail = ^chain[ORDER_CAP];

  generate
    for (genvar g = 0; g < ORDER_CAP; g++) begin : g_stage
      logic stage_en;
      logic stage_cin;
      assign stage_en  = (order_q > 3'(ORDER_INT + g));
      assign stage_cin = (g == 0) ? dith_bit : 1'b0;

      mash_acc_stage #(
        .FRAC_WIDTH (FRAC_WIDTH)
      ) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (stage_en),
        .clr    (clr),
        .in_val (chain[g]),
        .cin    (stage_cin),
        .sum    (chain[g+1]),
        .carry  (carry[g])
      );
    end
  endgenerate

  // Noise cancellation: e[k] belongs to stage k+1; e[ORDER_CAP] is the zero
  // terminator, and disabled stages contribute zero since their c and d are 0
  logic signed [Y_WIDTH-1:0] e [0:ORDER_CAP];
  logic signed [Y_WIDTH-1:0] d [1:ORDER_CAP];

  // Combinational cancellation network from the top stage down to y
  always_comb begin
    for (int k = 0; k <= ORDER_CAP; k++) begin
      e[k] = '0;
    end
    for (int k = ORDER_CAP - 1; k >= 0; k--) begin
      e[k] = $signed({{(Y_WIDTH-1){1'b0}}, carry[k]}) + e[k+1] - d[k+1];
    end
  end

  // One-cycle delay of each e for the (1 - z^-1) differentiators
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int k = 1; k <= ORDER_CAP; k++) begin
        d[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= ORDER_CAP; k++) begin
        d[k] <= e[k];
      end
    end
  end

  // Division value on INT_WIDTH+2 signed bits so a negative result is visible
  logic signed [INT_WIDTH+1:0] n_sum;
  assign n_sum = $signed({2'b00, int_q})
               + $signed({{(INT_WIDTH+2-Y_WIDTH){e[0][Y_WIDTH-1]}}, e[0]});

  // Registered outputs with clamp of negative division values to zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_o     <= '0;
      n_o     <= '0;
      clamp_o <= 1'b0;
    end else begin
      y_o <= e[0];
      if (n_sum[INT_WIDTH+1]) begin
        n_o     <= '0;
        clamp_o <= 1'b1;
      end else begin
        n_o     <= n_sum[INT_WIDTH:0];
        clamp_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mash_nth_dsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mash_nth_dsm
// Description : Self-checking bench for mash_nth_dsm against a behavioural
//               MASH model (per-stage carries, binomial noise shaping).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mash_nth_dsm;

  localparam int  F      = 24;
  localparam int  IW     = 8;
  localparam int  OMAX   = 3;
  localparam int  YW     = OMAX + 1;
  localparam longint MASK = (64'd1 << F) - 1;
  localparam int  SEED   = 23'h7FFFFF;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [IW-1:0]        int_i;
  logic [F-1:0]         frac_i;
  logic [2:0]           order_i;
  logic                 dither_en_i;
  logic                 load_i;
  logic signed [YW-1:0] y_o;
  logic [IW:0]          n_o;
  logic                 clamp_o;

  mash_nth_dsm #(
    .FRAC_WIDTH (F),
    .INT_WIDTH  (IW),
    .ORDER_MAX  (OMAX),
    .LFSR_SEED  (23'h7FFFFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .int_i       (int_i),
    .frac_i      (frac_i),
    .order_i     (order_i),
    .dither_en_i (dither_en_i),
    .load_i      (load_i),
    .y_o         (y_o),
    .n_o         (n_o),
    .clamp_o     (clamp_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single comparison point for every check
  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_acc  [1:4];
  int     m_hist [1:4][0:3];   // carry history per stage, [0] = newest
  int     m_lfsr;
  int     m_int, m_order, m_dith;
  longint m_frac;
  int     m_y, m_n, m_clamp, m_ord_used;

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  task automatic model_clear_state();
    for (int k = 1; k <= 4; k++) begin
      m_acc[k] = 0;
      for (int j = 0; j < 4; j++) m_hist[k][j] = 0;
    end
    m_lfsr = SEED;
  endtask

  task automatic model_step();
    longint s, inv;
    longint nacc [1:4];
    int     c    [1:4];
    int     y, tot, ord_new;
    if (!rst_n) begin
      model_clear_state();
      m_int = 0; m_frac = 0; m_order = OMAX; m_dith = 0;
      m_y = 0; m_n = 0; m_clamp = 0; m_ord_used = 0;
      return;
    end
    inv = m_frac + ((m_dith != 0 && (m_lfsr & 1) != 0) ? 1 : 0);
    for (int k = 1; k <= 4; k++) begin c[k] = 0; nacc[k] = 0; end
    for (int k = 1; k <= m_order; k++) begin
      s       = m_acc[k] + inv;
      c[k]    = int'(s >> F);
      nacc[k] = s & MASK;
      inv     = nacc[k];
    end
    for (int k = 1; k <= 4; k++) begin
      for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = c[k];
    end
    // y = sum_k (1 - z^-1)^(k-1) c_k
    y = 0;
    for (int k = 1; k <= m_order; k++)
      for (int j = 0; j < k; j++)
        y += ((j % 2) ? -1 : 1) * binom(k - 1, j) * m_hist[k][j];
    m_y = y;
    m_ord_used = m_order;
    tot = m_int + y;
    if (tot < 0) begin m_n = 0; m_clamp = 1; end
    else begin m_n = tot; m_clamp = 0; end
    for (int k = 1; k <= 4; k++) m_acc[k] = nacc[k];
    if (m_dith != 0)
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 22) ^ (m_lfsr >> 17)) & 1)) & SEED;
    if (load_i) begin
      ord_new = (int'(order_i) > OMAX) ? OMAX : int'(order_i);
      if (ord_new != m_order) model_clear_state();
      m_int = int'(int_i); m_frac = longint'(frac_i);
      m_order = ord_new; m_dith = int'(dither_en_i);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    int lo, hi;
    @(posedge clk);
    #1;
    model_step();
    check("y_o", longint'(y_o), longint'(m_y));
    check("n_o", longint'(n_o), longint'(m_n));
    check("clamp_o", longint'(clamp_o), longint'(m_clamp));
    lo = (m_ord_used == 0) ? 0 : -((1 << (m_ord_used - 1)) - 1);
    hi = (m_ord_used == 0) ? 0 : (1 << (m_ord_used - 1));
    if (rst_n) check("y_range", (int'(y_o) >= lo && int'(y_o) <= hi) ? 1 : 0, 1);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input int ord, input longint fr, input int iv, input int dith);
    order_i     = 3'(ord);
    frac_i      = F'(fr);
    int_i       = IW'(iv);
    dither_en_i = (dith != 0);
    load_i      = 1'b1;
    step();
    load_i      = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    run(n);
    rst_n = 1'b1;
  endtask

  longint ysum, yexp;

  initial begin
    rst_n = 1'b0; int_i = '0; frac_i = '0; order_i = '0;
    dither_en_i = 1'b0; load_i = 1'b0;
    model_clear_state();
    m_int = 0; m_frac = 0; m_order = OMAX; m_dith = 0;
    m_y = 0; m_n = 0; m_clamp = 0; m_ord_used = 0;

    // Reset, with load asserted to confirm reset wins
    load_i = 1'b1; frac_i = 24'h123456; int_i = 8'd99;
    do_reset(3);
    load_i = 1'b0;
    check("rst_y", longint'(y_o), 0);
    check("rst_n_o", longint'(n_o), 0);
    check("rst_clamp", longint'(clamp_o), 0);

    // Order 1, half fraction: 0,1,0,1...
    do_load(1, 64'd8388608, 120, 0);
    run(20);

    // Order 3 near-half fraction: long-run mean
    do_load(3, 64'd8388607, 120, 0);
    ysum = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      ysum += longint'(y_o);
    end
    yexp = (64'd4000 * 64'd8388607) >> F;
    check("frac_sum_within_4", (ysum >= yexp - 4 && ysum <= yexp + 4) ? 1 : 0, 1);

    // Integer-N and clamped order request
    do_load(0, 64'd8388607, 57, 0);
    run(50);
    check("intn_n_o", longint'(n_o), 57);
    do_load(7, 64'd8388607, 57, 0);
    run(50);

    // Same-order fraction change, then order change 3 -> 2
    do_load(3, 64'd8388608, 120, 0);
    run(30);
    do_load(3, 64'd4194304, 120, 0);
    run(30);
    do_load(2, 64'd4194304, 120, 0);
    run(40);

    // Small integer: negative sums clamp to zero
    do_load(3, 64'd8388608, 1, 0);
    run(300);
    do_load(3, 64'd8388608, 0, 0);
    run(100);

    // Dither with zero fraction, then reset mid-run
    do_load(1, 0, 100, 1);
    run(3000);
    do_reset(1);
    check("midrst_y", longint'(y_o), 0);
    run(20);
    do_load(1, 0, 100, 1);
    run(200);
    do_load(3, 64'd1234567, 100, 1);
    run(500);

    // Randomized loads and occasional resets
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 1999) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      if ($urandom_range(0, 63) == 0) begin
        load_i      = 1'b1;
        order_i     = 3'($urandom_range(0, 7));
        frac_i      = F'($urandom);
        int_i       = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 3)) : IW'($urandom);
        dither_en_i = 1'($urandom_range(0, 1));
      end else begin
        load_i = 1'b0;
      end
      step();
    end
    rst_n  = 1'b1;
    load_i = 1'b0;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
